// File: rtl/node_mac_seq.sv
// node_mac_seq: one neuron evaluated sequentially. Each accepted activation
// beat is multiplied by weight[idx] and folded into a running IEEE-754 single
// sum. One shared multiplier and one shared adder serve all inputs.
// Optional feature macro: NODE_MAC_SEQ_RELU_EN (sign-bit ReLU on the result).
// Handshakes: a beat moves when a_valid && a_ready; a result moves when
// n_valid && n_ready. A valid holder keeps its data stable until the transfer.
// Arithmetic: round-to-nearest-even; subnormals flush to signed zero;
// overflow gives signed infinity. NaN inputs are not propagated.

module float_mult (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic              sign;
  logic [47:0]       prod;
  logic [24:0]       mant;
  logic              guard;
  logic              sticky;
  logic signed [9:0] exp;

  // Normalised significand product, then round-to-nearest-even.
  always_comb begin
    sign   = a[31] ^ b[31];
    prod   = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    exp    = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (prod[47]) begin
      mant   = {1'b0, prod[47:24]};
      guard  = prod[23];
      sticky = |prod[22:0];
      exp    = exp + 10'sd1;
    end else begin
      mant   = {1'b0, prod[46:23]};
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    if (guard && (sticky || mant[0])) mant = mant + 25'd1;
    if (mant[24]) begin
      mant = mant >> 1;
      exp  = exp + 10'sd1;
    end
    y = {sign, exp[7:0], mant[22:0]};
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF || exp >= 10'sd255)
      y = {sign, 8'hFF, 23'd0};
    else if (a[30:23] == 8'd0 || b[30:23] == 8'd0 || exp <= 10'sd0 || !mant[23])
      y = {sign, 31'd0};
  end
endmodule

module float_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic [31:0]       big;
  logic [31:0]       sml;
  logic [7:0]        d8;
  logic [4:0]        dsh;
  logic [26:0]       mb;
  logic [26:0]       ms;
  logic [26:0]       ms_sh;
  logic [26:0]       mask;
  logic [27:0]       sum;
  logic              is_zero;
  logic signed [9:0] exp;
  logic [4:0]        lz;
  logic              found;
  logic [24:0]       mant;

  // Align the smaller operand (with sticky), add/subtract, normalise, round.
  always_comb begin
    if (a[30:0] >= b[30:0]) begin
      big = a;
      sml = b;
    end else begin
      big = b;
      sml = a;
    end
    d8    = big[30:23] - sml[30:23];
    mb    = {1'b1, big[22:0], 3'b000};
    ms    = {1'b1, sml[22:0], 3'b000};
    dsh   = 5'd0;
    mask  = 27'd0;
    if (d8 > 8'd26) begin
      // Whole smaller operand falls below the round bits: only sticky survives.
      ms_sh = 27'd1;
    end else begin
      dsh   = d8[4:0];
      mask  = (27'd1 << dsh) - 27'd1;
      ms_sh = (ms >> dsh) | {26'd0, |(ms & mask)};
    end
    if (big[31] == sml[31]) sum = {1'b0, mb} + {1'b0, ms_sh};
    else                    sum = {1'b0, mb} - {1'b0, ms_sh};
    is_zero = (sum == 28'd0);
    exp     = $signed({2'b00, big[30:23]});
    if (sum[27]) begin
      sum = {1'b0, sum[27:2], sum[1] | sum[0]};
      exp = exp + 10'sd1;
    end
    lz    = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && sum[i]) begin
        lz    = 5'(26 - i);
        found = 1'b1;
      end
    end
    sum  = sum << lz;
    exp  = exp - $signed({5'd0, lz});
    mant = {1'b0, sum[26:3]};
    if (sum[2] && (sum[1] || sum[0] || mant[0])) mant = mant + 25'd1;
    if (mant[24]) begin
      mant = mant >> 1;
      exp  = exp + 10'sd1;
    end
    y = {big[31], exp[7:0], mant[22:0]};
    if (a[30:23] == 8'd0 && b[30:23] == 8'd0) y = {a[31] & b[31], 31'd0};
    else if (sml[30:23] == 8'd0)               y = big;
    else if (big[30:23] == 8'hFF)              y = big;
    else if (is_zero)                          y = 32'd0;
    else if (exp >= 10'sd255)                  y = {big[31], 8'hFF, 23'd0};
    else if (exp <= 10'sd0 || !mant[23])       y = {big[31], 31'd0};
  end
endmodule

module node_mac_seq #(
  parameter int          N_IN  = 15,
  parameter logic [31:0] W_RST = 32'hBE273BB2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        w_wr_en,
  input  logic [3:0]  w_addr,
  input  logic [31:0] w_data,
  input  logic        a_valid,
  input  logic [31:0] a_data,
  output logic        a_ready,
  output logic        n_valid,
  input  logic        n_ready,
  output logic [31:0] n_data,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, OUT = 2'd2} state_t;

  localparam logic [3:0] LAST_IDX = 4'(N_IN - 1);
  localparam logic [4:0] N_IN_W   = 5'(N_IN);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] n_data_q, n_data_d;
  logic [31:0] weight_q [N_IN];
  logic [31:0] weight_d [N_IN];
  logic [31:0] prod;
  logic [31:0] sum;

  float_mult  u_mult (.a(a_data), .b(weight_q[idx_q]), .y(prod));
  float_adder u_add  (.a(acc_q),  .b(prod),            .y(sum));

`ifdef NODE_MAC_SEQ_RELU_EN
  // Sign-bit rule: anything with bit 31 set (including -0) becomes +0.
  function automatic logic [31:0] post_op(input logic [31:0] v);
    return v[31] ? 32'd0 : v;
  endfunction
`else
  function automatic logic [31:0] post_op(input logic [31:0] v);
    return v;
  endfunction
`endif

  // Next-state, accumulation and weight-write logic.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    n_data_d = n_data_q;
    weight_d = weight_q;
    case (state_q)
      IDLE: begin
        if (w_wr_en && ({1'b0, w_addr} < N_IN_W)) weight_d[w_addr] = w_data;
        if (start) begin
          state_d = ACC;
          idx_d   = 4'd0;
        end
      end
      ACC: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = 4'd0;
          acc_d   = 32'd0;
        end else if (a_valid) begin
          acc_d = (idx_q == 4'd0) ? prod : sum;
          idx_d = idx_q + 4'd1;
          if (idx_q == LAST_IDX) begin
            state_d  = OUT;
            idx_d    = 4'd0;
            n_data_d = post_op(acc_d);
          end
        end
      end
      OUT: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = 4'd0;
          acc_d   = 32'd0;
        end else if (n_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset restores every weight slot to W_RST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= 4'd0;
      acc_q    <= 32'd0;
      n_data_q <= 32'd0;
      for (int i = 0; i < N_IN; i++) weight_q[i] <= W_RST;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      n_data_q <= n_data_d;
      weight_q <= weight_d;
    end
  end

  assign a_ready = (state_q == ACC);
  assign n_valid = (state_q == OUT);
  assign busy    = (state_q != IDLE);
  assign n_data  = n_data_q;
endmodule

// File: tb/tb_node_mac_seq.sv
// Bench for node_mac_seq: directed scenarios plus randomized evaluations,
// checked against a real-arithmetic model that rounds every product and
// partial sum to single precision.
`timescale 1ns/1ps
module tb_node_mac_seq;
  localparam int          N_IN  = 15;
  localparam logic [31:0] W_RST = 32'hBE273BB2;
  localparam logic [31:0] ONE   = 32'h3F800000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        w_wr_en = 1'b0;
  logic [3:0]  w_addr = 4'd0;
  logic [31:0] w_data = 32'd0;
  logic        a_valid = 1'b0;
  logic [31:0] a_data = 32'd0;
  logic        n_ready = 1'b0;
  logic        a_ready;
  logic        n_valid;
  logic [31:0] n_data;
  logic        busy;

  int checks = 0;
  int passed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_w [N_IN];
  logic [31:0] acts [N_IN];

  node_mac_seq #(.N_IN(N_IN), .W_RST(W_RST)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .n_valid(n_valid), .n_ready(n_ready), .n_data(n_data), .busy(busy)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  function automatic real f2r(input logic [31:0] x);
    real m;
    int  e;
    if (x[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return x[31] ? -m : m;
  endfunction

  // Round a real to the nearest single (ties to even).
  function automatic logic [31:0] r2f(input real r);
    real    a, sc, fl;
    int     e;
    longint f;
    logic   s;
    logic [7:0] be;
    if (r == 0.0) return 32'd0;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    sc = (a - 1.0) * 8388608.0;
    fl = $floor(sc);
    f  = longint'(fl);
    if ((sc - fl > 0.5) || (sc - fl == 0.5 && f[0])) f++;
    if (f == 64'd8388608) begin f = 0; e++; end
    if (e + 127 >= 255) return {s, 8'hFF, 23'd0};
    if (e + 127 <= 0)   return {s, 31'd0};
    be = 8'(e + 127);
    return {s, be, f[22:0]};
  endfunction

  function automatic logic [31:0] model_eval();
    real acc, p;
    logic [31:0] res;
    acc = 0.0;
    for (int i = 0; i < N_IN; i++) begin
      p = f2r(r2f(f2r(acts[i]) * f2r(model_w[i])));
      acc = (i == 0) ? p : f2r(r2f(acc + p));
    end
    res = r2f(acc);
`ifdef NODE_MAC_SEQ_RELU_EN
    if (res[31]) res = 32'd0;
`endif
    return res;
  endfunction

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (rst_n && n_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_n_valid: got n_valid=1 n_data=%08h expected n_valid=0", n_data);
      end else begin
        chk("n_data", n_data, exp_q[0]);
        if (n_ready || abort) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_w(input logic [3:0] addr, input logic [31:0] d, input bit upd);
    w_wr_en = 1'b1; w_addr = addr; w_data = d;
    if (upd && addr < N_IN) model_w[addr] = d;
    tick();
    w_wr_en = 1'b0;
  endtask

  task automatic do_start(input bit wr, input logic [3:0] addr, input logic [31:0] d);
    start = 1'b1;
    if (wr) begin
      w_wr_en = 1'b1; w_addr = addr; w_data = d;
      if (addr < N_IN) model_w[addr] = d;
    end
    tick();
    start = 1'b0; w_wr_en = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic send_beats(input int from, input int to, input int gmin, input int gmax);
    bit ok;
    ok = 1'b1;
    for (int i = from; i < to; i++) begin
      repeat ($urandom_range(gmin, gmax)) begin
        a_valid = 1'b0;
        if (!a_ready || n_valid) ok = 1'b0;
        tick();
      end
      a_valid = 1'b1; a_data = acts[i];
      if (!a_ready || n_valid) ok = 1'b0;
      tick();
    end
    a_valid = 1'b0;
    chk("a_ready_held_in_acc", {31'd0, ok}, 32'd1);
  endtask

  task automatic finish_out(input int max_hold);
    chk("n_valid_after_last_beat", {31'd0, n_valid}, 32'd1);
    chk("a_ready_low_in_out", {31'd0, a_ready}, 32'd0);
    repeat ($urandom_range(0, max_hold)) tick();
    n_ready = 1'b1;
    tick();
    n_ready = 1'b0;
    chk("idle_after_accept", {30'd0, busy, n_valid}, 32'd0);
  endtask

  task automatic run_eval(input int gmin, input int gmax, input int max_hold,
                          input bit wr, input logic [3:0] addr, input logic [31:0] d);
    if (wr && addr < N_IN) model_w[addr] = d;
    exp_q.push_back(model_eval());
    do_start(wr, addr, d);
    send_beats(0, N_IN, gmin, gmax);
    finish_out(max_hold);
  endtask

  function automatic logic [31:0] rand_act();
    real r;
    r = real'($urandom_range(1, 16));
    repeat ($urandom_range(0, 2)) r = r / 2.0;
    return r2f($urandom_range(0, 1) ? -r : r);
  endfunction

  function automatic logic [31:0] rand_w();
    real r;
    r = real'($urandom_range(1, 8)) / 8.0;
    return r2f($urandom_range(0, 1) ? -r : r);
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] e;
    for (int i = 0; i < N_IN; i++) model_w[i] = W_RST;

    // Reset state
    #2;
    chk("reset_outputs", {a_ready, n_valid, busy, 29'd0}, 32'd0);
    chk("reset_n_data", n_data, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // All weights 1.0, 15 beats of 1.0 back-to-back -> 15.0
    for (int i = 0; i < N_IN; i++) write_w(4'(i), ONE, 1'b1);
    for (int i = 0; i < N_IN; i++) acts[i] = ONE;
    chk("model_pin_15", model_eval(), 32'h41700000);
    run_eval(0, 0, 0, 1'b0, 4'd0, 32'd0);

    // Weight write together with start is used by this evaluation -> 16.0
    model_w[14] = 32'h40000000;
    chk("model_pin_16", model_eval(), 32'h41800000);
    model_w[14] = ONE;
    run_eval(0, 0, 2, 1'b1, 4'd14, 32'h40000000);
    write_w(4'd14, ONE, 1'b1);

    // Beats 1..15 with a gap before every beat -> 120.0
    for (int i = 0; i < N_IN; i++) acts[i] = r2f(real'(i + 1));
    chk("model_pin_120", model_eval(), 32'h42F00000);
    run_eval(1, 1, 3, 1'b0, 4'd0, 32'd0);

    // All weights -1.0, beats 1.0 -> -15.0 raw, 0 after ReLU
    for (int i = 0; i < N_IN; i++) write_w(4'(i), 32'hBF800000, 1'b1);
    for (int i = 0; i < N_IN; i++) acts[i] = ONE;
`ifdef NODE_MAC_SEQ_RELU_EN
    chk("model_pin_neg", model_eval(), 32'h00000000);
`else
    chk("model_pin_neg", model_eval(), 32'hC1700000);
`endif
    run_eval(0, 2, 1, 1'b0, 4'd0, 32'd0);

    // Abort after 7 beats, then a clean rerun -> 15.0
    for (int i = 0; i < N_IN; i++) write_w(4'(i), ONE, 1'b1);
    do_start(1'b0, 4'd0, 32'd0);
    send_beats(0, 7, 0, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_after_abort", {30'd0, busy, n_valid}, 32'd0);
    repeat (3) tick();
    chk("no_output_after_abort", {31'd0, n_valid}, 32'd0);
    run_eval(0, 0, 1, 1'b0, 4'd0, 32'd0);

    // Write during ACC is ignored; start during OUT is ignored
    exp_q.push_back(model_eval());
    do_start(1'b0, 4'd0, 32'd0);
    send_beats(0, 3, 0, 0);
    write_w(4'd0, 32'h40000000, 1'b0);
    send_beats(3, N_IN, 0, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_out_ignored", {30'd0, busy, n_valid}, 32'd3);
    finish_out(2);

    // Randomized evaluations with random weight updates, gaps and holds
    for (int t = 0; t < 14; t++) begin
      repeat ($urandom_range(0, 4)) write_w(4'($urandom_range(0, 15)), rand_w(), 1'b1);
      for (int i = 0; i < N_IN; i++) acts[i] = rand_act();
      run_eval(0, $urandom_range(0, 3), 3, 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), rand_w());
    end

    // Reset after 5 beats: outputs drop at once, weights return to W_RST
    for (int i = 0; i < N_IN; i++) acts[i] = ONE;
    do_start(1'b0, 4'd0, 32'd0);
    send_beats(0, 5, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("async_reset_flags", {29'd0, a_ready, n_valid, busy}, 32'd0);
    chk("async_reset_n_data", n_data, 32'd0);
    exp_q.delete();
    for (int i = 0; i < N_IN; i++) model_w[i] = W_RST;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    e = model_eval();
`ifdef NODE_MAC_SEQ_RELU_EN
    chk("model_pin_rst", e, 32'h00000000);
`else
    chk("model_pin_rst_sign", {31'd0, e[31]}, 32'd1);
`endif
    run_eval(0, 0, 1, 1'b0, 4'd0, 32'd0);

    repeat (2) tick();
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
